// File: rtl/calc_resp_merge.sv
// Merges the four calculator DUT response ports into one valid/ready stream through per-port
// FIFOs and a round-robin arbiter. Define CALC_RESP_MERGE_STATS_EN to build the resp_cnt counters.
module calc_resp_merge #(
    parameter int unsigned CALC_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                       PClk,
    input  logic                       Rst,
    input  logic [1:0]                 out_resp1,
    input  logic [1:0]                 out_resp2,
    input  logic [1:0]                 out_resp3,
    input  logic [1:0]                 out_resp4,
    input  logic [CALC_DATA_WIDTH-1:0] out_data1,
    input  logic [CALC_DATA_WIDTH-1:0] out_data2,
    input  logic [CALC_DATA_WIDTH-1:0] out_data3,
    input  logic [CALC_DATA_WIDTH-1:0] out_data4,
    input  logic [1:0]                 out_tag1,
    input  logic [1:0]                 out_tag2,
    input  logic [1:0]                 out_tag3,
    input  logic [1:0]                 out_tag4,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [1:0]                 m_port,
    output logic [1:0]                 m_resp,
    output logic [CALC_DATA_WIDTH-1:0] m_data,
    output logic [1:0]                 m_tag,
    output logic [3:0]                 drop_err,
    output logic [63:0]                resp_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = CALC_DATA_WIDTH + 4;

    // FIFO entry layout: {resp, data, tag}
    logic [1:0]    in_resp  [4];
    logic [EW-1:0] in_entry [4];

    assign in_resp[0]  = out_resp1;
    assign in_resp[1]  = out_resp2;
    assign in_resp[2]  = out_resp3;
    assign in_resp[3]  = out_resp4;
    assign in_entry[0] = {out_resp1, out_data1, out_tag1};
    assign in_entry[1] = {out_resp2, out_data2, out_tag2};
    assign in_entry[2] = {out_resp3, out_data3, out_tag3};
    assign in_entry[3] = {out_resp4, out_data4, out_tag4};

    logic [EW-1:0] mem_q    [4][FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q [4];
    logic [AW:0]   rd_ptr_q [4];
    logic [EW-1:0] head     [4];
    logic [3:0]    empty;
    logic [3:0]    full;
    logic [3:0]    push_ok;
    logic [3:0]    drop;
    logic [3:0]    pop;

    logic                       m_valid_q;
    logic [1:0]                 m_port_q;
    logic [1:0]                 m_resp_q;
    logic [CALC_DATA_WIDTH-1:0] m_data_q;
    logic [1:0]                 m_tag_q;
    logic [3:0]                 drop_err_q;
    logic [1:0]                 rr_ptr_q;

    logic       load;
    logic       found;
    logic [1:0] gnt_port;

    assign load = !m_valid_q || m_ready;

    // Full when the pointers differ only in their wrap bit.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
            full[p]  = (wr_ptr_q[p][AW] != rd_ptr_q[p][AW]) &&
                       (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]);
            head[p]  = mem_q[p][rd_ptr_q[p][AW-1:0]];
        end
    end

    always_comb begin
        logic [1:0] idx;
        found    = 1'b0;
        gnt_port = rr_ptr_q;
        idx      = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found && !empty[idx]) begin
                found    = 1'b1;
                gnt_port = idx;
            end
        end
        pop = (load && found) ? (4'b0001 << gnt_port) : 4'b0000;
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            push_ok[p] = (in_resp[p] != 2'b00) && (!full[p] || pop[p]);
            drop[p]    = (in_resp[p] != 2'b00) && full[p] && !pop[p];
        end
    end

    always_ff @(posedge PClk) begin
        for (int p = 0; p < 4; p++) begin
            if (push_ok[p]) begin
                mem_q[p][wr_ptr_q[p][AW-1:0]] <= in_entry[p];
            end
        end
    end

    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) begin
            for (int p = 0; p < 4; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
            end
            drop_err_q <= 4'b0000;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (push_ok[p]) wr_ptr_q[p] <= wr_ptr_q[p] + 1'b1;
                if (pop[p])     rd_ptr_q[p] <= rd_ptr_q[p] + 1'b1;
            end
            drop_err_q <= drop_err_q | drop;
        end
    end

    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) begin
            m_valid_q <= 1'b0;
            m_port_q  <= 2'b00;
            m_resp_q  <= 2'b00;
            m_data_q  <= '0;
            m_tag_q   <= 2'b00;
            rr_ptr_q  <= 2'b00;
        end else if (load) begin
            m_valid_q <= found;
            if (found) begin
                m_port_q                       <= gnt_port;
                {m_resp_q, m_data_q, m_tag_q} <= head[gnt_port];
                rr_ptr_q                       <= gnt_port + 2'd1;
            end
        end
    end

    assign m_valid  = m_valid_q;
    assign m_port   = m_port_q;
    assign m_resp   = m_resp_q;
    assign m_data   = m_data_q;
    assign m_tag    = m_tag_q;
    assign drop_err = drop_err_q;

`ifdef CALC_RESP_MERGE_STATS_EN
    logic [15:0] cnt_q [4];

    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) begin
            for (int p = 0; p < 4; p++) cnt_q[p] <= 16'h0000;
        end else if (m_valid_q && m_ready && (cnt_q[m_port_q] != 16'hFFFF)) begin
            cnt_q[m_port_q] <= cnt_q[m_port_q] + 16'h0001;
        end
    end

    assign resp_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
    assign resp_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_calc_resp_merge.sv
// Self-checking bench for calc_resp_merge: directed vector table, hand-written overflow/reset
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_calc_resp_merge;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;

    logic          PClk = 1'b0;
    logic          Rst  = 1'b0;
    logic [1:0]    t_resp [4];
    logic [W-1:0]  t_data [4];
    logic [1:0]    t_tag  [4];
    logic          m_ready = 1'b0;
    logic          m_valid;
    logic [1:0]    m_port;
    logic [1:0]    m_resp;
    logic [W-1:0]  m_data;
    logic [1:0]    m_tag;
    logic [3:0]    drop_err;
    logic [63:0]   resp_cnt;

    int nerr    = 0;
    int nchecks = 0;

    always #5 PClk = ~PClk;

    calc_resp_merge #(.CALC_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .PClk(PClk), .Rst(Rst),
        .out_resp1(t_resp[0]), .out_resp2(t_resp[1]), .out_resp3(t_resp[2]), .out_resp4(t_resp[3]),
        .out_data1(t_data[0]), .out_data2(t_data[1]), .out_data3(t_data[2]), .out_data4(t_data[3]),
        .out_tag1(t_tag[0]), .out_tag2(t_tag[1]), .out_tag3(t_tag[2]), .out_tag4(t_tag[3]),
        .m_valid(m_valid), .m_ready(m_ready), .m_port(m_port), .m_resp(m_resp),
        .m_data(m_data), .m_tag(m_tag), .drop_err(drop_err), .resp_cnt(resp_cnt)
    );

    // Reference model: one queue per port plus the output-stage contents.
    logic [W+3:0] mq [4][$];
    logic         mv;
    logic [1:0]   mp;
    logic [W+3:0] mo;
    int           mptr;
    logic [3:0]   mdrop;
    logic [15:0]  mcnt [4];

    task automatic model_reset();
        for (int p = 0; p < 4; p++) begin
            mq[p].delete();
            mcnt[p] = 16'h0;
        end
        mv = 1'b0; mp = 2'd0; mo = '0; mptr = 0; mdrop = 4'b0;
    endtask

    task automatic model_step();
        if (mv && m_ready && mcnt[mp] != 16'hFFFF) mcnt[mp] = mcnt[mp] + 16'h1;
        if (!mv || m_ready) begin
            mv = 1'b0;
            for (int i = 0; i < 4; i++) begin
                int p;
                p = (mptr + i) % 4;
                if (!mv && mq[p].size() > 0) begin
                    mo = mq[p].pop_front();
                    mp = 2'(p);
                    mv = 1'b1;
                end
            end
            if (mv) mptr = (int'(mp) + 1) % 4;
        end
        for (int p = 0; p < 4; p++) begin
            if (t_resp[p] != 2'b00) begin
                if (mq[p].size() < DEPTH) mq[p].push_back({t_resp[p], t_data[p], t_tag[p]});
                else mdrop[p] = 1'b1;
            end
        end
    endtask

    function automatic logic [63:0] model_cnt();
`ifdef CALC_RESP_MERGE_STATS_EN
        return {mcnt[3], mcnt[2], mcnt[1], mcnt[0]};
`else
        return 64'h0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            t_resp[p] = 2'b00; t_data[p] = '0; t_tag[p] = 2'b00;
        end
    endtask

    // Asserted between edges; reset outputs must be visible before the next edge.
    task automatic do_reset();
        clear_inputs();
        Rst = 1'b1;
        #1;
        chk("rst_valid", 64'(m_valid), 64'h0);
        chk("rst_fields", 64'({m_port, m_resp, m_data, m_tag}), 64'h0);
        chk("rst_drop", 64'(drop_err), 64'h0);
        chk("rst_cnt", resp_cnt, 64'h0);
        @(posedge PClk);
        #1;
        Rst = 1'b0;
        model_reset();
    endtask

    task automatic step();
        @(posedge PClk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic [7:0]   r;
        logic [127:0] d;
        logic [7:0]   t;
        logic         rdy;
        logic         ev;
        logic [1:0]   ep;
        logic [1:0]   er;
        logic [31:0]  ed;
        logic [1:0]   et;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic rst, input logic [7:0] r, input logic [127:0] d,
                                input logic [7:0] t, input logic rdy, input logic ev,
                                input logic [1:0] ep, input logic [1:0] er,
                                input logic [31:0] ed, input logic [1:0] et);
        vec_t v;
        v.rst = rst; v.r = r; v.d = d; v.t = t; v.rdy = rdy;
        v.ev = ev; v.ep = ep; v.er = er; v.ed = ed; v.et = et;
        return v;
    endfunction

    initial begin
        logic [63:0] exp_cnt;
        clear_inputs();
        model_reset();
        #1;

        // Single response on port index 1.
        tbl.push_back(mk(1, 8'b00_00_01_00, {32'd0, 32'd0, 32'd5, 32'd0}, 8'b00_00_10_00,
                         1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h0, '0, 8'h0, 1, 1, 2'd1, 2'b01, 32'd5, 2'd2));
        tbl.push_back(mk(0, 8'h0, '0, 8'h0, 1, 0, 0, 0, 0, 0));
        // Four-port capture, then a port-0 response waits for the pointer to wrap.
        tbl.push_back(mk(1, 8'b01_01_01_01, {32'd44, 32'd33, 32'd22, 32'd11}, 8'b11_10_01_00,
                         1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h0, '0, 8'h0, 1, 1, 2'd0, 2'b01, 32'd11, 2'd0));
        tbl.push_back(mk(0, 8'b00_00_00_01, {96'd0, 32'd55}, 8'b00_00_00_01,
                         1, 1, 2'd1, 2'b01, 32'd22, 2'd1));
        tbl.push_back(mk(0, 8'h0, '0, 8'h0, 1, 1, 2'd2, 2'b01, 32'd33, 2'd2));
        tbl.push_back(mk(0, 8'h0, '0, 8'h0, 1, 1, 2'd3, 2'b01, 32'd44, 2'd3));
        tbl.push_back(mk(0, 8'h0, '0, 8'h0, 1, 1, 2'd0, 2'b01, 32'd55, 2'd1));
        tbl.push_back(mk(0, 8'h0, '0, 8'h0, 1, 0, 0, 0, 0, 0));
        // Backpressure hold on port index 3, then exactly one handshake.
        tbl.push_back(mk(1, 8'b10_00_00_00, '0, 8'b11_00_00_00, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 8'h0, '0, 8'h0, 0, 1, 2'd3, 2'b10, 32'd0, 2'd3));
        tbl.push_back(mk(0, 8'h0, '0, 8'h0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h0, '0, 8'h0, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            for (int p = 0; p < 4; p++) begin
                t_resp[p] = tbl[i].r[2*p +: 2];
                t_data[p] = tbl[i].d[32*p +: 32];
                t_tag[p]  = tbl[i].t[2*p +: 2];
            end
            m_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d_valid", i), 64'(m_valid), 64'(tbl[i].ev));
            if (tbl[i].ev)
                chk($sformatf("vec%0d_beat", i), 64'({m_port, m_resp, m_data, m_tag}),
                    64'({tbl[i].ep, tbl[i].er, tbl[i].ed, tbl[i].et}));
        end

        // Overflow on port index 1: one in the output stage, four buffered, sixth dropped.
        m_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            t_resp[1] = 2'b01; t_data[1] = 32'(k); t_tag[1] = 2'd1;
            step();
            chk($sformatf("ovf_drop%0d", k), 64'(drop_err), (k == 6) ? 64'h2 : 64'h0);
        end
        clear_inputs();
        chk("ovf_hold", 64'({m_valid, m_data}), 64'({1'b1, 32'd1}));
        m_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            chk($sformatf("ovf_beat%0d", k), 64'({m_valid, m_data}), 64'({1'b1, 32'(k)}));
        end
        step();
        chk("ovf_empty", 64'(m_valid), 64'h0);
        chk("ovf_sticky", 64'(drop_err), 64'h2);

        // Reset mid-operation with buffered data and a sticky drop flag.
        m_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            clear_inputs();
            if (k <= 4) begin
                t_resp[0] = 2'b01; t_data[0] = 32'(k);
            end
            t_resp[3] = 2'b11; t_data[3] = 32'(100 + k);
            step();
        end
        clear_inputs();
        chk("mid_pre", 64'({m_valid, m_port, m_data, drop_err}), 64'({1'b1, 2'd0, 32'd1, 4'b1000}));
        #3;
        Rst = 1'b1;
        #1;
        chk("mid_valid", 64'(m_valid), 64'h0);
        chk("mid_drop", 64'(drop_err), 64'h0);
        chk("mid_data", 64'(m_data), 64'h0);
        @(posedge PClk);
        #1;
        Rst = 1'b0;
        model_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("mid_post%0d", k), 64'(m_valid), 64'h0);
        end

        // Counters: three from port index 0, two from port index 3.
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            t_resp[0] = 2'b01; t_data[0] = 32'(k);
            if (k < 2) begin
                t_resp[3] = 2'b10; t_data[3] = 32'(k);
            end
            step();
        end
        clear_inputs();
        for (int k = 0; k < 8; k++) step();
`ifdef CALC_RESP_MERGE_STATS_EN
        exp_cnt = 64'h0002_0000_0000_0003;
`else
        exp_cnt = 64'h0;
`endif
        chk("stats", resp_cnt, exp_cnt);

        // Randomized traffic against the reference model, with bursts of heavy backpressure.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 4; p++) begin
                t_resp[p] = ($urandom_range(0, 4) < 2) ? 2'($urandom_range(1, 3)) : 2'b00;
                t_data[p] = $urandom;
                t_tag[p]  = 2'($urandom_range(0, 3));
            end
            if ((i % 64) < 20) m_ready = ($urandom_range(0, 4) == 0);
            else m_ready = ($urandom_range(0, 3) != 0);
            step();
            chk("rnd_valid", 64'(m_valid), 64'(mv));
            if (mv) chk("rnd_beat", 64'({m_port, m_resp, m_data, m_tag}), 64'({mp, mo}));
            chk("rnd_drop", 64'(drop_err), 64'(mdrop));
            chk("rnd_cnt", resp_cnt, model_cnt());
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/calc_resp_merge.md
Name: calc_resp_merge

Overview:
- Downstream stage of the calculator DUT interface. Samples the four DUT response ports (out_resp/out_data/out_tag 1..4) every PClk.
- Each valid response is buffered in a per-port FIFO. A round-robin arbiter merges them into one valid/ready stream for the scoreboard/monitor logic.
- Overflowing responses are dropped and flagged, never silently lost.

Parameters:
- CALC_DATA_WIDTH, 32, width of response data.
- FIFO_DEPTH, 4, entries per port FIFO; power of 2, minimum 2.

Ports:
- PClk  input  1  clock; all logic is on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- out_resp1..out_resp4  input  2 each  DUT response code; 2'b00 means no response.
- out_data1..out_data4  input  CALC_DATA_WIDTH each  DUT result data.
- out_tag1..out_tag4  input  2 each  DUT response tag.
- m_valid  output  1  merged response valid.
- m_ready  input  1  consumer accepts when m_valid && m_ready at a rising edge.
- m_port  output  2  source port, 0..3 = port 1..4.
- m_resp  output  2  response code.
- m_data  output  CALC_DATA_WIDTH  response data.
- m_tag  output  2  response tag.
- drop_err  output  4  sticky per-port overflow flags.
- resp_cnt  output  64  four 16-bit forwarded-response counters; port p occupies bits [16p+15:16p].

Behaviour:
- Reset (asynchronous, active-high; valid when asserted mid-transfer):
  - All FIFOs empty; arbiter pointer = port 0.
  - m_valid=0; m_port, m_resp, m_data, m_tag = 0.
  - drop_err=0; resp_cnt=0.
  - Any in-flight or buffered responses are discarded.
- Capture:
  - At each rising edge, any port with out_resp != 2'b00 pushes {resp, data, tag} into that port's FIFO.
  - Codes 01, 10 and 11 are all captured unmodified.
  - All four ports may push in the same cycle.
- Overflow:
  - A push is accepted if count < FIFO_DEPTH, or if that FIFO is popped in the same cycle.
  - Otherwise the response is dropped, drop_err[p] is set, and the bit stays set until Rst.
  - FIFO contents are unchanged on a drop.
- Pointers: read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full/empty are derived from the MSB comparison.
- Output register (one-entry output stage):
  - The stage loads when m_valid=0, or when m_valid && m_ready.
  - On load, the arbiter selects a non-empty FIFO, pops its head, and drives m_* registered. m_valid=1 if a grant occurred, else 0.
  - While m_valid=1 && m_ready=0, all m_* outputs hold stable.
- Arbitration: round-robin starting from the pointer. After a grant to port p, the pointer becomes (p+1) mod 4. With no grant, the pointer is unchanged.
- Latency:
  - A response captured at edge k can appear with m_valid=1 after edge k+1 (FIFO empty, output stage free).
  - Full throughput is one response per cycle with m_ready held high.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle keeps the count unchanged.
  - A response captured at edge k is not visible to the arbiter until after edge k (no bypass).
- resp_cnt: counter p increments on each handshake where m_port=p. It saturates at 16'hFFFF.

Optional Feature:
- Macro: CALC_RESP_MERGE_STATS_EN.
- Defined: resp_cnt counters are implemented as described above.
- Not defined: no counter logic is built and resp_cnt is tied to 64'h0. All other behaviour is identical.

Test Plan:
- Single response: Rst pulse, then port 2 drives resp=01, data=32'h0000_0005, tag=2 for one cycle, m_ready=1 -> after the following edge m_valid=1, m_port=1, m_resp=01, m_data=5, m_tag=2 for exactly one cycle.
- Simultaneous four-port capture: all ports drive resp=01 in one cycle, data=11/22/33/44, m_ready=1 -> four consecutive beats in order port 0,1,2,3 with data 11,22,33,44. A later single port-0 response is granted next only after the pointer has wrapped.
- Backpressure hold: m_ready=0 while port 3 responds with resp=10, data=0 -> m_valid=1 and all m_* fields stay stable for 10 cycles; release m_ready -> exactly one handshake.
- Overflow: m_ready=0, port 1 issues 6 responses with FIFO_DEPTH=4 -> output stage holds 1, FIFO holds 4, the 6th is dropped and drop_err=4'b0010. Release m_ready -> 5 beats with data in issue order, then drop_err remains 4'b0010.
- Reset mid-operation: with 3 responses buffered and m_valid=1, assert Rst asynchronously between edges -> m_valid=0 and drop_err=0 immediately; after deassertion there is no residual output.
- Stats (macro defined): 3 responses forwarded from port 0 and 2 from port 3 -> resp_cnt=64'h0002_0000_0000_0003. With the macro undefined -> resp_cnt=0.
